// File: rtl/uart_rx_read_arb.sv
// uart_rx_read_arb: round-robin arbiter and read sequencer that shares the
// single read port of the UART RX FIFO among NREQ clients. A granted client
// receives a burst of req_len+1 bytes. A burst that stalls for TIMEOUT
// consecutive empty cycles is aborted.
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   req, req_len    per-client request level and burst length minus 1 (4 bits each)
//   gnt             one-hot grant, held for the whole burst
//   rd_data         byte for the granted client (valid with rd_valid)
//   rd_valid        rd_data valid this cycle
//   done            one-cycle pulse with the last byte of a completed burst
//   tmo             one-cycle pulse when a burst is aborted by timeout
//   fifo_rd_en      FIFO read strobe (combinational from state and fifo_empty)
//   fifo_dout       FIFO output, valid the cycle after fifo_rd_en
//   fifo_empty      FIFO empty flag
module uart_rx_read_arb #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned DW      = 8,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*4-1:0] req_len,
  output logic [NREQ-1:0]   gnt,
  output logic [DW-1:0]     rd_data,
  output logic              rd_valid,
  output logic              done,
  output logic              tmo,
  output logic              fifo_rd_en,
  input  logic [DW-1:0]     fifo_dout,
  input  logic              fifo_empty
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned LW = 4;
  localparam int unsigned CW = LW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_LAST  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   rr_q, rr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [LW-1:0]   len_q, len_d;
  logic [CW-1:0]   issued_q, issued_d;
  logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic            done_q, done_d;
  logic            tmo_q, tmo_d;
  logic            rd_valid_q;
  logic [DW-1:0]   hold_q;

  logic            pick_found;
  logic [PW-1:0]   pick_idx;
  logic [PW-1:0]   cand;
  logic [NREQ-1:0] pick_oh;
  logic [LW-1:0]   pick_len;

  // Reads only while bursting and only when the FIFO has data.
  assign fifo_rd_en = (state_q == S_BURST) && !fifo_empty;

  // FIFO output is already registered: pass it through on the valid cycle,
  // otherwise present the last delivered byte.
  assign rd_data  = rd_valid_q ? fifo_dout : hold_q;
  assign rd_valid = rd_valid_q;
  assign gnt      = gnt_q;
  assign done     = done_q;
  assign tmo      = tmo_q;

  // Round-robin pick: first requester at or after rr_q, searching upward.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_oh    = '0;
    pick_len   = '0;
    cand       = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = PW'((32'(rr_q) + k) % NREQ);
      if (!pick_found && req[cand]) begin
        pick_found    = 1'b1;
        pick_idx      = cand;
        pick_oh       = '0;
        pick_oh[cand] = 1'b1;
        pick_len      = req_len[{cand, 2'b00} +: LW];
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    gnt_d     = gnt_q;
    len_d     = len_q;
    issued_d  = issued_q;
    tmo_cnt_d = tmo_cnt_q;
    done_d    = 1'b0;
    tmo_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          state_d   = S_BURST;
          gnt_d     = pick_oh;
          len_d     = pick_len;
          rr_d      = PW'((32'(pick_idx) + 32'd1) % NREQ);
          issued_d  = '0;
          tmo_cnt_d = '0;
        end
      end
      S_BURST: begin
        if (!fifo_empty) begin
          issued_d  = issued_q + CW'(1);
          tmo_cnt_d = '0;
          // This read is the (len+1)-th: its byte arrives in LAST with done.
          if (issued_q == CW'(len_q)) begin
            state_d = S_LAST;
            done_d  = 1'b1;
          end
        end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
          state_d = S_IDLE;
          gnt_d   = '0;
          tmo_d   = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      S_LAST: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rr_q       <= '0;
      gnt_q      <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      tmo_cnt_q  <= '0;
      done_q     <= 1'b0;
      tmo_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      gnt_q      <= gnt_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      tmo_cnt_q  <= tmo_cnt_d;
      done_q     <= done_d;
      tmo_q      <= tmo_d;
      rd_valid_q <= fifo_rd_en;
      hold_q     <= rd_data;
    end
  end

endmodule

// File: tb/tb_uart_rx_read_arb.sv
// Testbench for uart_rx_read_arb: bench-side FIFO model, scoreboard of bytes
// pushed into the FIFO, and a burst-level reference model of grants, done,
// timeout and read strobes checked every cycle by a monitor.
module tb_uart_rx_read_arb;

  localparam int NREQ    = 4;
  localparam int DW      = 8;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*4-1:0] req_len = '0;
  logic [NREQ-1:0]   gnt;
  logic [DW-1:0]     rd_data;
  logic              rd_valid;
  logic              done;
  logic              tmo;
  logic              fifo_rd_en;
  logic [DW-1:0]     fifo_dout = '0;
  logic              fifo_empty = 1'b1;

  always #5 clk = ~clk;

  uart_rx_read_arb #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .req_len(req_len), .gnt(gnt),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .tmo(tmo),
    .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] fifoq[$];
  logic [7:0] exp_data[$];
  int         gnt_log[$];

  int cnt_rden, cnt_valid, cnt_done, cnt_tmo, cnt_gnt_cyc;
  int prev_gnt_act;

  int feed_mode = 0, feed_period = 7, feed_left = 0, feed_ctr = 0;
  logic [7:0] feed_val = 8'h50;

  // Monitor / model state.
  bit armed = 0;
  bit pop_pend = 0;
  int e_gnt, e_valid, e_tmo, e_done, e_rden, bursting;
  int m_len, m_got, m_issued, m_run, m_rr, last_data, w_pick;
  logic [7:0] exp_b;

  task automatic chk(input string nm, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic void push_byte(input logic [7:0] b);
    fifoq.push_back(b);
    exp_data.push_back(b);
  endfunction

  function automatic int oh_idx(input logic [NREQ-1:0] v);
    int r = -1;
    if ($countones(v) != 1) return -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic void model_reset();
    e_gnt = 0; e_valid = 0; e_tmo = 0; m_rr = 0; last_data = 0;
    m_run = 0; m_issued = 0; m_got = 0; m_len = 0;
  endfunction

  // FIFO model: pops on the edge after a sampled read strobe, then feeds.
  always begin
    @(posedge clk);
    #1;
    if (pop_pend && fifoq.size() > 0) fifo_dout = fifoq.pop_front();
    #1;
    if (feed_mode == 1) begin
      if (feed_left > 0) begin
        feed_ctr++;
        if (feed_ctr >= feed_period) begin
          feed_ctr = 0;
          feed_left--;
          push_byte(feed_val);
          feed_val++;
        end
      end
    end else if (feed_mode == 2) begin
      if ($urandom_range(0, 3) == 0) push_byte(8'($urandom));
    end
    fifo_empty = (fifoq.size() == 0);
  end

  // Monitor: compares DUT outputs to the model each cycle, then advances the model.
  always @(negedge clk) begin
    pop_pend = (fifo_rd_en === 1'b1);
    if (!armed) begin
      if (reset === 1'b1) begin
        model_reset();
        armed = 1;
      end
    end else begin
      if (fifo_rd_en) cnt_rden++;
      if (rd_valid) cnt_valid++;
      if (done) cnt_done++;
      if (tmo) cnt_tmo++;
      if (gnt != 0) cnt_gnt_cyc++;
      if (gnt != 0 && prev_gnt_act == 0) gnt_log.push_back(oh_idx(gnt));
      prev_gnt_act = int'(gnt);

      chk("gnt", int'(gnt), e_gnt);
      chk("tmo", int'(tmo), e_tmo);
      chk("rd_valid", int'(rd_valid), e_valid);
      chk("gnt_onehot", int'($countones(gnt) > 1), 0);
      chk("done_and_tmo", int'(done && tmo), 0);
      chk("rd_en_when_empty", int'(fifo_rd_en && fifo_empty), 0);
      bursting = int'((e_gnt != 0) && (m_issued < m_len + 1));
      e_rden   = int'((bursting != 0) && !fifo_empty);
      chk("fifo_rd_en", int'(fifo_rd_en), e_rden);

      e_done = 0;
      if (e_valid != 0) begin
        m_got++;
        if (exp_data.size() == 0) begin
          chk("scoreboard_empty", 1, 0);
        end else begin
          exp_b = exp_data.pop_front();
          chk("rd_data", int'(rd_data), int'(exp_b));
          last_data = int'(exp_b);
        end
        e_done = int'(m_got == m_len + 1);
      end else begin
        chk("rd_data_hold", int'(rd_data), last_data);
      end
      chk("done", int'(done), e_done);

      if (reset) begin
        // A read issued in the reset cycle pops a byte that is never delivered.
        if (fifo_rd_en && exp_data.size() > 0) void'(exp_data.pop_front());
        model_reset();
      end else begin
        e_valid = e_rden;
        e_tmo   = 0;
        if (e_gnt == 0) begin
          w_pick = -1;
          for (int k = 0; k < NREQ; k++)
            if (w_pick < 0 && req[(m_rr + k) % NREQ]) w_pick = (m_rr + k) % NREQ;
          if (w_pick >= 0) begin
            e_gnt    = 1 << w_pick;
            m_rr     = (w_pick + 1) % NREQ;
            m_len    = int'((req_len >> (4 * w_pick)) & 16'hF);
            m_issued = 0;
            m_run    = 0;
            m_got    = 0;
          end
        end else if (e_done != 0) begin
          e_gnt = 0;
        end else if (bursting != 0) begin
          if (fifo_empty) begin
            m_run++;
            if (m_run == TIMEOUT) begin
              e_gnt = 0;
              e_tmo = 1;
            end
          end else begin
            m_issued++;
            m_run = 0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int evt_val(input int which);
    case (which)
      0: return cnt_done;
      1: return cnt_tmo;
      2: return gnt_log.size();
      default: return cnt_rden;
    endcase
  endfunction

  task automatic wait_evt(input string nm, input int which, input int target, input int maxc);
    for (int i = 0; i < maxc; i++) begin
      if (evt_val(which) >= target) break;
      tick();
    end
    chk(nm, evt_val(which), target);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    req_len = '0;
    feed_mode = 0;
    tick();
    tick();
    fifoq.delete();
    exp_data.delete();
    gnt_log.delete();
    cnt_rden = 0; cnt_valid = 0; cnt_done = 0; cnt_tmo = 0; cnt_gnt_cyc = 0;
    prev_gnt_act = 0;
    reset = 1'b0;
  endtask

  task automatic drain(input string nm);
    int stable = 0;
    req = '0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (gnt == 0 && !rd_valid) stable++;
      else stable = 0;
      if (stable >= 3) break;
    end
    chk(nm, int'(gnt), 0);
  endtask

  function automatic int log_at(input int i);
    if (i < gnt_log.size()) return gnt_log[i];
    return -1;
  endfunction

  initial begin
    // Single burst, no stalls.
    do_reset();
    for (int i = 0; i < 4; i++) push_byte(8'(8'h11 + i));
    req_len = 16'h0300;
    req = 4'b0100;
    wait_evt("t1_grant", 2, 1, 20);
    req = '0;
    wait_evt("t1_done", 0, 1, 30);
    tick(); tick();
    chk("t1_rden_pulses", cnt_rden, 4);
    chk("t1_bytes", cnt_valid, 4);
    chk("t1_gnt_cycles", cnt_gnt_cyc, 5);
    chk("t1_client", log_at(0), 2);

    // Round robin with single-byte bursts.
    do_reset();
    for (int i = 0; i < 8; i++) push_byte(8'(8'h20 + i));
    req = 4'b1111;
    wait_evt("t2_dones", 0, 8, 60);
    drain("t2_drain");
    for (int i = 0; i < 8; i++) chk("t2_rr_order", log_at(i), i % NREQ);

    // Stall gaps at baud-tick spacing.
    do_reset();
    feed_mode = 1; feed_period = 7; feed_left = 3; feed_ctr = 0;
    req_len = 16'h2000;
    req = 4'b1000;
    wait_evt("t3_done", 0, 1, 80);
    drain("t3_drain");
    chk("t3_bytes", cnt_valid, 3);
    chk("t3_reads", cnt_rden, 3);
    chk("t3_tmo", cnt_tmo, 0);

    // Timeout after one byte, then the next requester is served.
    do_reset();
    push_byte(8'hA5);
    req_len = 16'h0030;
    req = 4'b0110;
    wait_evt("t4_tmo", 1, 1, 60);
    chk("t4_bytes", cnt_valid, 1);
    wait_evt("t4_next_grant", 2, 2, 10);
    chk("t4_first", log_at(0), 1);
    chk("t4_second", log_at(1), 2);
    drain("t4_drain");

    // Reset in the cycle of the second read of a burst.
    do_reset();
    for (int i = 0; i < 6; i++) push_byte(8'(8'h31 + i));
    req_len = 16'h0300;
    req = 4'b0100;
    begin
      bit hit = 0;
      for (int i = 0; i < 20; i++) begin
        tick();
        #2;
        if (fifo_rd_en && cnt_rden == 1) begin
          hit = 1;
          break;
        end
      end
      chk("t5_found_read", int'(hit), 1);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_gnt_after_reset", int'(gnt), 0);
    chk("t5_valid_after_reset", int'(rd_valid), 0);
    req_len = 16'h0301;
    req = 4'b0101;
    wait_evt("t5_regrant", 2, 2, 10);
    chk("t5_client0_wins", log_at(1), 0);
    wait_evt("t5_done", 0, 1, 20);
    drain("t5_drain");
    chk("t5_bytes", cnt_valid, 3);

    // Request withdrawn right after grant.
    do_reset();
    for (int i = 0; i < 3; i++) push_byte(8'(8'h61 + i));
    req_len = 16'h0010;
    req = 4'b1010;
    wait_evt("t6_grant", 2, 1, 10);
    req = 4'b1000;
    wait_evt("t6_dones", 0, 2, 30);
    drain("t6_drain");
    chk("t6_first", log_at(0), 1);
    chk("t6_second", log_at(1), 3);
    chk("t6_bytes", cnt_valid, 3);

    // Randomized traffic with occasional resets.
    do_reset();
    feed_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        req = 4'($urandom);
        req_len = 16'($urandom);
      end
      reset = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset = 1'b0;
    drain("t7_drain");
    feed_mode = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
